// File: rtl/imem_program_loader_if.sv
// Byte-stream handshake into the boot loader.
// The source drives data/valid; the loader answers with ready.
interface imem_program_loader_if;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;

   modport master (output rx_data, output rx_valid, input rx_ready);
   modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/imem_program_loader.sv
// Boot loader: assembles a length-prefixed, XOR-checked byte stream into
// instruction-memory writes and holds the core in reset until it is verified.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | waiting for COUNT_LO
// S_CNT_HI | waiting for COUNT_HI, then range-check N
// S_DATA   | assembling little-endian words, one write per 4 bytes
// S_CHK    | waiting for the XOR checksum byte
// S_RUN    | image verified, core released
// S_ERR    | image rejected, core held
module imem_program_loader #(
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   imem_program_loader_if.slave  rx,
   input  logic                  load_req,
   output logic                  imem_we,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   output logic [31:0]           imem_wdata,
   output logic                  cpu_rst_n,
   output logic                  done,
   output logic                  error,
   output logic [15:0]           words_loaded
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CNT_HI,
      S_DATA,
      S_CHK,
      S_RUN,
      S_ERR
   } state_t;

   localparam logic [16:0]           DEPTH_L  = 17'd1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0]   ONE_WORD = 1;
   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;

   state_t                state, state_nx;
   logic [7:0]            cnt_lo;
   logic [ADDR_WIDTH:0]   words_left;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [1:0]            byte_idx;
   logic [23:0]           asm_word;
   logic [7:0]            chk_acc;

   logic                  accept;
   logic [15:0]           n_full;
   logic                  count_bad;
   logic                  word_done;
   logic                  last_word;

   assign rx.rx_ready = rst_n & ~load_req &
                        (state inside {S_IDLE, S_CNT_HI, S_DATA, S_CHK});
   assign accept      = rx.rx_valid & rx.rx_ready;
   assign n_full      = {rx.rx_data, cnt_lo};
   assign count_bad   = (n_full == 16'd0) || ({1'b0, n_full} > DEPTH_L);
   assign word_done   = accept && (state == S_DATA) && (byte_idx == 2'd3);
   assign last_word   = word_done && (words_left == ONE_WORD);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      if (load_req) begin
         state_nx = S_IDLE;
      end else begin
         case (state)
            S_IDLE:   if (accept) state_nx = S_CNT_HI;
            S_CNT_HI: if (accept) state_nx = count_bad ? S_ERR : S_DATA;
            S_DATA:   if (last_word) state_nx = S_CHK;
            S_CHK:    if (accept) state_nx = (rx.rx_data == chk_acc) ? S_RUN : S_ERR;
            default:  state_nx = state;
         endcase
      end
   end

   // Status flags follow the next state so they settle one edge after the deciding byte.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cpu_rst_n <= 1'b0;
         done      <= 1'b0;
         error     <= 1'b0;
      end else begin
         cpu_rst_n <= (state_nx == S_RUN);
         done      <= (state_nx == S_RUN);
         error     <= (state_nx == S_ERR);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_lo       <= '0;
         words_left   <= '0;
         wr_addr      <= '0;
         byte_idx     <= '0;
         asm_word     <= '0;
         chk_acc      <= '0;
         imem_we      <= 1'b0;
         imem_addr    <= '0;
         imem_wdata   <= '0;
         words_loaded <= '0;
      end else begin
         imem_we <= 1'b0;
         if (load_req) begin
            byte_idx     <= '0;
            chk_acc      <= '0;
            words_loaded <= '0;
         end else if (accept) begin
            case (state)
               S_IDLE: cnt_lo <= rx.rx_data;
               S_CNT_HI: begin
                  words_left <= n_full[ADDR_WIDTH:0];
                  wr_addr    <= '0;
                  byte_idx   <= '0;
                  chk_acc    <= '0;
               end
               S_DATA: begin
                  chk_acc  <= chk_acc ^ rx.rx_data;
                  byte_idx <= byte_idx + 2'd1;
                  case (byte_idx)
                     2'd0: asm_word[7:0]   <= rx.rx_data;
                     2'd1: asm_word[15:8]  <= rx.rx_data;
                     2'd2: asm_word[23:16] <= rx.rx_data;
                     default: begin
                        imem_we      <= 1'b1;
                        imem_addr    <= wr_addr;
                        imem_wdata   <= {rx.rx_data, asm_word};
                        wr_addr      <= wr_addr + ADDR_ONE;
                        words_left   <= words_left - ONE_WORD;
                        words_loaded <= words_loaded + 16'd1;
                     end
                  endcase
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_imem_program_loader.sv
// Directed bench for imem_program_loader: good/bad images, count bounds,
// back-pressure, load_req restarts and mid-word asynchronous reset.
module tb_imem_program_loader;

   logic        clk;
   logic        rst_n;
   logic        load_req;
   logic        imem_we;
   logic [7:0]  imem_addr;
   logic [31:0] imem_wdata;
   logic        cpu_rst_n;
   logic        done;
   logic        error;
   logic [15:0] words_loaded;

   imem_program_loader_if rx_if ();

   imem_program_loader #(.ADDR_WIDTH(8)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .rx           (rx_if),
      .load_req     (load_req),
      .imem_we      (imem_we),
      .imem_addr    (imem_addr),
      .imem_wdata   (imem_wdata),
      .cpu_rst_n    (cpu_rst_n),
      .done         (done),
      .error        (error),
      .words_loaded (words_loaded)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_errors = 0;
   int          wr_cnt   = 0;
   int          acc_cnt  = 0;
   logic [7:0]  log_addr [0:1023];
   logic [31:0] log_data [0:1023];
   logic [7:0]  frame [$];

   // Write and handshake monitors sample mid-cycle.
   always @(negedge clk) begin
      if (imem_we === 1'b1) begin
         if (wr_cnt < 1024) begin
            log_addr[wr_cnt] <= imem_addr;
            log_data[wr_cnt] <= imem_wdata;
         end
         wr_cnt <= wr_cnt + 1;
      end
      if (rx_if.rx_valid === 1'b1 && rx_if.rx_ready === 1'b1)
         acc_cnt <= acc_cnt + 1;
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic to_drive();
      @(posedge clk);
      #1;
   endtask

   // Called at posedge+1; returns at posedge+1 after the byte was taken.
   task automatic send_byte(input logic [7:0] b);
      int n;
      rx_if.rx_data  = b;
      rx_if.rx_valid = 1'b1;
      n = 0;
      @(negedge clk);
      while (rx_if.rx_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (rx_if.rx_ready !== 1'b1) check_val("rx_ready_wait", 32'(rx_if.rx_ready), 32'd1);
      to_drive();
      rx_if.rx_valid = 1'b0;
   endtask

   task automatic send_frame(input int max_gap);
      foreach (frame[i]) begin
         send_byte(frame[i]);
         if (max_gap > 0) repeat ($urandom_range(0, max_gap)) to_drive();
      end
   endtask

   task automatic pulse_load();
      load_req = 1'b1;
      @(negedge clk);
      check_val("ready_during_load", 32'(rx_if.rx_ready), 32'd0);
      to_drive();
      load_req = 1'b0;
   endtask

   int          base;
   int          abase;
   logic [7:0]  chk;
   logic [31:0] w;

   initial begin
      rst_n          = 1'b0;
      load_req       = 1'b0;
      rx_if.rx_valid = 1'b0;
      rx_if.rx_data  = 8'h00;

      // Reset values
      repeat (2) @(negedge clk);
      check_val("rst_rx_ready", 32'(rx_if.rx_ready), 32'd0);
      check_val("rst_imem_we", 32'(imem_we), 32'd0);
      check_val("rst_imem_addr", 32'(imem_addr), 32'd0);
      check_val("rst_imem_wdata", imem_wdata, 32'd0);
      check_val("rst_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
      check_val("rst_done", 32'(done), 32'd0);
      check_val("rst_error", 32'(error), 32'd0);
      check_val("rst_words", 32'(words_loaded), 32'd0);
      to_drive();
      rst_n = 1'b1;
      @(negedge clk);
      check_val("idle_rx_ready", 32'(rx_if.rx_ready), 32'd1);
      to_drive();

      // Good single-word image
      base  = wr_cnt;
      frame = '{8'h01, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'hC3};
      send_frame(0);
      @(negedge clk);
      check_val("good_done", 32'(done), 32'd1);
      check_val("good_cpu_rst_n", 32'(cpu_rst_n), 32'd1);
      check_val("good_words", 32'(words_loaded), 32'd1);
      check_val("good_rx_ready", 32'(rx_if.rx_ready), 32'd0);
      check_val("good_error", 32'(error), 32'd0);
      check_val("good_wr_count", 32'(wr_cnt - base), 32'd1);
      check_val("good_wr_addr", 32'(log_addr[base]), 32'd0);
      check_val("good_wr_data", log_data[base], 32'h00500093);
      to_drive();

      // load_req in RUN drops the core reset next cycle
      pulse_load();
      @(negedge clk);
      check_val("run_reload_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
      check_val("run_reload_done", 32'(done), 32'd0);
      to_drive();

      // Bad checksum
      base  = wr_cnt;
      frame = '{8'h01, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'hC4};
      send_frame(0);
      @(negedge clk);
      check_val("badchk_error", 32'(error), 32'd1);
      check_val("badchk_done", 32'(done), 32'd0);
      check_val("badchk_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
      check_val("badchk_wr_count", 32'(wr_cnt - base), 32'd1);
      check_val("badchk_wr_data", log_data[base], 32'h00500093);
      check_val("err_rx_ready", 32'(rx_if.rx_ready), 32'd0);
      to_drive();

      // Count 257: too large
      pulse_load();
      @(negedge clk);
      check_val("reload_error_clear", 32'(error), 32'd0);
      to_drive();
      base  = wr_cnt;
      frame = '{8'h01, 8'h01};
      send_frame(0);
      @(negedge clk);
      check_val("cnt257_error", 32'(error), 32'd1);
      check_val("cnt257_no_write", 32'(wr_cnt - base), 32'd0);
      to_drive();

      // Count 0
      pulse_load();
      base  = wr_cnt;
      frame = '{8'h00, 8'h00};
      send_frame(0);
      @(negedge clk);
      check_val("cnt0_error", 32'(error), 32'd1);
      check_val("cnt0_no_write", 32'(wr_cnt - base), 32'd0);
      to_drive();

      // Count 256: full memory
      pulse_load();
      base  = wr_cnt;
      chk   = 8'h00;
      frame = '{8'h00, 8'h01};
      for (int i = 0; i < 256; i++) begin
         w = {8'(i), 8'(i * 3), 8'hA5, 8'(~i)};
         for (int k = 0; k < 4; k++) begin
            frame.push_back(w[8*k +: 8]);
            chk = chk ^ w[8*k +: 8];
         end
      end
      frame.push_back(chk);
      send_frame(0);
      @(negedge clk);
      check_val("full_done", 32'(done), 32'd1);
      check_val("full_words", 32'(words_loaded), 32'd256);
      check_val("full_wr_count", 32'(wr_cnt - base), 32'd256);
      check_val("full_first_addr", 32'(log_addr[base]), 32'd0);
      check_val("full_last_addr", 32'(log_addr[base + 255]), 32'd255);
      check_val("full_last_data", log_data[base + 255], {8'd255, 8'(255 * 3), 8'hA5, 8'd0});
      to_drive();

      // Two words with random valid gaps
      pulse_load();
      base  = wr_cnt;
      abase = acc_cnt;
      frame = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00,
                8'h13, 8'h01, 8'hA0, 8'h00, 8'h71};
      send_frame(3);
      repeat (2) @(negedge clk);
      check_val("bp_done", 32'(done), 32'd1);
      check_val("bp_accepted", 32'(acc_cnt - abase), 32'd11);
      check_val("bp_wr_count", 32'(wr_cnt - base), 32'd2);
      check_val("bp_addr0", 32'(log_addr[base]), 32'd0);
      check_val("bp_data0", log_data[base], 32'h00500093);
      check_val("bp_addr1", 32'(log_addr[base + 1]), 32'd1);
      check_val("bp_data1", log_data[base + 1], 32'h00A00113);
      to_drive();

      // load_req after 6 bytes, with a byte offered in the same cycle
      pulse_load();
      frame = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00};
      send_frame(0);
      abase          = acc_cnt;
      rx_if.rx_data  = 8'h13;
      rx_if.rx_valid = 1'b1;
      load_req       = 1'b1;
      @(negedge clk);
      check_val("midload_ready", 32'(rx_if.rx_ready), 32'd0);
      to_drive();
      load_req       = 1'b0;
      rx_if.rx_valid = 1'b0;
      @(negedge clk);
      check_val("midload_words", 32'(words_loaded), 32'd0);
      check_val("midload_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
      check_val("midload_idle_ready", 32'(rx_if.rx_ready), 32'd1);
      check_val("midload_no_accept", 32'(acc_cnt - abase), 32'd0);
      to_drive();
      base  = wr_cnt;
      frame = '{8'h01, 8'h00, 8'h13, 8'h01, 8'hA0, 8'h00, 8'hB2};
      send_frame(0);
      @(negedge clk);
      check_val("reload_done", 32'(done), 32'd1);
      check_val("reload_wr_count", 32'(wr_cnt - base), 32'd1);
      check_val("reload_wr_addr", 32'(log_addr[base]), 32'd0);
      check_val("reload_wr_data", log_data[base], 32'h00A00113);
      to_drive();

      // rst_n mid-word after 2 bytes of the second word
      pulse_load();
      frame = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01};
      send_frame(0);
      rst_n = 1'b0;
      #1;
      check_val("arst_words", 32'(words_loaded), 32'd0);
      check_val("arst_wdata", imem_wdata, 32'd0);
      check_val("arst_we", 32'(imem_we), 32'd0);
      check_val("arst_ready", 32'(rx_if.rx_ready), 32'd0);
      check_val("arst_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
      base = wr_cnt;
      repeat (3) to_drive();
      rst_n = 1'b1;
      frame = '{8'h01, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'hC3};
      send_frame(0);
      @(negedge clk);
      check_val("post_rst_done", 32'(done), 32'd1);
      check_val("post_rst_wr_count", 32'(wr_cnt - base), 32'd1);
      check_val("post_rst_wr_data", log_data[base], 32'h00500093);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/imem_program_loader.md
# imem_program_loader

Boot-time loader that sits directly upstream of the single-cycle core (`monocicle`). It accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words. It writes those words into the instruction memory's write port and holds the core in reset until a complete, checksum-verified image has been loaded. After a good load it releases the core; after a bad load it flags an error and keeps the core held.

## Interface
- `ADDR_WIDTH`, 8, instruction-memory word-address width; capacity DEPTH = 2^ADDR_WIDTH words
- `clk`  in  1  clock, all state updates on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `rx_data`  in  8  incoming byte
- `rx_valid`  in  1  `rx_data` valid
- `rx_ready`  out  1  loader can accept a byte; a byte transfers on `rx_valid & rx_ready` at a rising edge
- `load_req`  in  1  single-cycle pulse; restarts loading from any state
- `imem_we`  out  1  instruction-memory write strobe, one cycle per word
- `imem_addr`  out  ADDR_WIDTH  word index being written
- `imem_wdata`  out  32  instruction word
- `cpu_rst_n`  out  1  reset to core; low holds core, high releases
- `done`  out  1  image loaded and verified
- `error`  out  1  load rejected
- `words_loaded`  out  16  number of words written in the current load

## Operation
- Frame format:
  - COUNT_LO, COUNT_HI: N, 16-bit little-endian.
  - 4·N data bytes, each word least-significant byte first.
  - CHK byte: XOR of all data bytes (count bytes excluded).
- FSM states: IDLE, CNT_HI, DATA, CHK, RUN, ERR.
  - IDLE: accept byte → latch count[7:0] → CNT_HI.
  - CNT_HI: accept byte → form N.
    - N == 0 or N > DEPTH → ERR.
    - Otherwise → DATA, with byte index = 0, word address = 0, chk accumulator = 0.
  - DATA: each accepted byte shifts into the assembly register at byte lane [index] and XORs into the accumulator.
    - On lane 3, the word is complete: it is registered to `imem_wdata`/`imem_addr` and `imem_we` is pulsed.
    - After a completed word, if the word count reaches N → CHK.
  - CHK: accept byte. Byte == accumulator → RUN; otherwise → ERR.
  - RUN: `done`=1, `cpu_rst_n`=1, `rx_ready`=0.
  - ERR: `error`=1, `cpu_rst_n`=0, `rx_ready`=0.
  - `load_req` in any state:
    - → IDLE next cycle.
    - Clears `done`, `error`, `words_loaded`, the accumulator and byte index.
    - Drives `cpu_rst_n`=0.
    - A byte presented in that same cycle is not accepted.
- `rx_ready` = 1 in IDLE, CNT_HI, DATA, CHK; 0 in RUN, ERR, and in the cycle `load_req` is high.
- `words_loaded` increments by 1 in the cycle `imem_we` is high; it saturates at N.
- Addresses start at 0 and increment by 1 per word. No wrap, because N ≤ DEPTH is enforced before any write.
- Memory contents outside 0..N-1 are not touched.

## Timing
- Reset values (asynchronous, while `rst_n`=0):
  - state = IDLE
  - `rx_ready`=1 (after deassertion; 0 while in reset)
  - `imem_we`=0, `imem_addr`=0, `imem_wdata`=0
  - `cpu_rst_n`=0, `done`=0, `error`=0, `words_loaded`=0
- `imem_we` is high for exactly one cycle: the cycle after the edge that accepted the word's 4th byte. `imem_addr`/`imem_wdata` are stable in that cycle.
- Back-to-back bytes every cycle are sustained with no stalls. A write pulse overlaps acceptance of the next word's first byte.
- `cpu_rst_n`, `done` and `error` are registered. They change on the edge after the final CHK/CNT_HI acceptance: 1-cycle latency.
- Gaps in `rx_valid` stall the FSM without state change.
- `rst_n` asserted mid-load: immediate return to reset values; a partial word is discarded.

## Test plan
- Good load, ADDR_WIDTH=8: stream 01 00 93 00 50 00 C3 at one byte per cycle.
  - One `imem_we` pulse with addr 0, data 0x00500093.
  - Next cycle after the C3 edge: `done`=1, `cpu_rst_n`=1, `words_loaded`=1, `rx_ready`=0.
- Bad checksum: same stream with last byte C4.
  - Write to addr 0 still occurs.
  - `error`=1, `done`=0, `cpu_rst_n` stays 0.
- Bounds:
  - Count 01 01 (257 > 256) → `error`=1 after the 2nd byte, no `imem_we`.
  - Count 00 00 → `error`=1 likewise.
  - Count 00 01 (256) accepted, ending at addr 255.
- Back-pressure: 2-word image (words 0x00500093, 0x00A00113; checksum = C3 ^ 13 ^ 01 ^ A0 = 71) with random `rx_valid` gaps.
  - Writes land at addr 0 then 1 with correct data.
  - No byte is consumed without a `rx_valid & rx_ready` edge.
- `load_req` mid-DATA after 6 bytes:
  - Next cycle: state IDLE, `words_loaded`=0, `cpu_rst_n`=0.
  - A fresh full frame then loads correctly.
  - `load_req` in RUN drops `cpu_rst_n` to 0 the next cycle.
- `rst_n` pulsed low mid-word (after 2 data bytes): all outputs return to reset values asynchronously, no stray `imem_we`.
